// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and read-source select for the register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {CLEAR, RUN} state_e;

  // Where a registered read takes its next value from
  typedef enum logic [1:0] {SRC_MEM, SRC_WD0, SRC_WD1, SRC_ZERO} rd_src_e;

  // Hardwired zero beats everything; port 1 beats port 0 when forwarding.
  function automatic rd_src_e rd_src_sel(input logic zero_hit,
                                         input logic bypass_en,
                                         input logic hit0,
                                         input logic hit1);
    rd_src_e src;
    src = SRC_MEM;
    if (zero_hit) begin
      src = SRC_ZERO;
    end else if (bypass_en && hit1) begin
      src = SRC_WD1;
    end else if (bypass_en && hit0) begin
      src = SRC_WD0;
    end
    return src;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write/read port bundle of the multiport register file
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic              re_a;
  logic [ADDR_W-1:0] ra_a;
  logic              re_b;
  logic [ADDR_W-1:0] ra_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              busy;
  logic              wr_conflict;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, re_a, ra_a, re_b, ra_b,
    input  rd_a, rd_b, busy, wr_conflict
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, re_a, ra_a, re_b, ra_b,
    output rd_a, rd_b, busy, wr_conflict
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - post-reset sequential clear engine, one entry per clock
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;

  // State and clear index registers; reset always restarts the sweep at entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Walk every entry once, then hand over to normal operation
  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (state == CLEAR) begin
      idx_n = idx + ADDR_W'(1);
      if (idx == '1) begin
        state_n = RUN;
      end
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_addr = idx;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - 2-write/2-read register file with bypass, zero entry and clear engine
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_multiport_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              w0_ok, w1_ok, collide;
  rd_src_e           src_a, src_b;
  logic [DATA_W-1:0] next_a, next_b;
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic              conflict_q;

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign run = !busy && !rst;

  // Writes to the hardwired-zero entry are dropped before they can collide or forward
  assign w0_ok   = run && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
  assign w1_ok   = run && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));
  assign collide = w0_ok && w1_ok && (bus.wa0 == bus.wa1);

  assign src_a = rd_src_sel((ZERO_REG != 0) && (bus.ra_a == '0), BYPASS != 0,
                            w0_ok && (bus.wa0 == bus.ra_a), w1_ok && (bus.wa1 == bus.ra_a));
  assign src_b = rd_src_sel((ZERO_REG != 0) && (bus.ra_b == '0), BYPASS != 0,
                            w0_ok && (bus.wa0 == bus.ra_b), w1_ok && (bus.wa1 == bus.ra_b));

  // Read-data muxes: zero entry, forwarded write data or stored contents
  always_comb begin
    next_a = mem[bus.ra_a];
    next_b = mem[bus.ra_b];
    case (src_a)
      SRC_ZERO: next_a = '0;
      SRC_WD1:  next_a = bus.wd1;
      SRC_WD0:  next_a = bus.wd0;
      default:  next_a = mem[bus.ra_a];
    endcase
    case (src_b)
      SRC_ZERO: next_b = '0;
      SRC_WD1:  next_b = bus.wd1;
      SRC_WD0:  next_b = bus.wd0;
      default:  next_b = mem[bus.ra_b];
    endcase
  end

  // Storage: clear engine first, then user ports with port 1 last so it wins a collision
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (w0_ok) mem[bus.wa0] <= bus.wd0;
      if (w1_ok) mem[bus.wa1] <= bus.wd1;
    end
  end

  // Registered read outputs and conflict pulse, forced quiet during reset and clear
  always_ff @(posedge clk) begin
    if (rst || busy) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= collide;
      if (bus.re_a) rd_a_q <= next_a;
      if (bus.re_b) rd_b_q <= next_b;
    end
  end

  assign bus.rd_a        = rd_a_q;
  assign bus.rd_b        = rd_b_q;
  assign bus.busy        = busy;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  assign bus_nb.we0  = bus.we0;
  assign bus_nb.wa0  = bus.wa0;
  assign bus_nb.wd0  = bus.wd0;
  assign bus_nb.we1  = bus.we1;
  assign bus_nb.wa1  = bus.wa1;
  assign bus_nb.wd1  = bus.wd1;
  assign bus_nb.re_a = bus.re_a;
  assign bus_nb.ra_a = bus.ra_a;
  assign bus_nb.re_b = bus.re_b;
  assign bus_nb.ra_b = bus.ra_b;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        re_a;
    logic [4:0]  ra_a;
    logic        re_b;
    logic [4:0]  ra_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_conf;
    logic [31:0] exp_nb_a;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = 5'd0; bus.wd0 = 32'd0;
    bus.we1 = 1'b0; bus.wa1 = 5'd0; bus.wd1 = 32'd0;
    bus.re_a = 1'b0; bus.ra_a = 5'd0;
    bus.re_b = 1'b0; bus.ra_b = 5'd0;
  endtask

  task automatic count_busy(output int n, output int noisy);
    n = 0;
    noisy = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.rd_a !== 32'd0 || bus.rd_b !== 32'd0 || bus.wr_conflict !== 1'b0) noisy++;
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int noisy;

    vecs[0]  = '{1'b1, 5'd7,  32'h11,   1'b1, 5'd7,  32'h22, 1'b0, 5'd0,  1'b0, 5'd0,  32'd310, 32'd300, 1'b1, 32'd310};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  1'b0, 5'd0,  32'h22,  32'd300, 1'b0, 32'h22};
    vecs[2]  = '{1'b1, 5'd5,  32'h55,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h22,  32'd300, 1'b0, 32'h22};
    vecs[3]  = '{1'b1, 5'd5,  32'h99,   1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  1'b0, 5'd0,  32'h99,  32'd300, 1'b0, 32'h55};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  1'b0, 5'd0,  32'h99,  32'd300, 1'b0, 32'h99};
    vecs[5]  = '{1'b1, 5'd9,  32'hA0,   1'b1, 5'd9,  32'hB0, 1'b1, 5'd9,  1'b1, 5'd9,  32'hB0,  32'hB0,  1'b1, 32'd90};
    vecs[6]  = '{1'b1, 5'd13, 32'hD0,   1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 1'b1, 5'd13, 32'hC0,  32'hD0,  1'b0, 32'd120};
    vecs[7]  = '{1'b1, 5'd0,  32'hFF,   1'b1, 5'd0,  32'hEE, 1'b1, 5'd0,  1'b1, 5'd12, 32'h0,   32'hC0,  1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  1'b1, 5'd13, 32'h0,   32'hD0,  1'b0, 32'h0};
    vecs[9]  = '{1'b1, 5'd13, 32'h77,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd13, 32'h0,   32'hD0,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd1,  32'h0,   32'hD0,  1'b0, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd2,  32'h0,   32'hD0,  1'b0, 32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd3,  32'h0,   32'hD0,  1'b0, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd13, 32'h0,   32'h77,  1'b0, 32'h0};

    idle();
    rst = 1'b1;
    tick();
    tick();
    check("reset_rd_a", bus.rd_a, 32'd0);
    check("reset_rd_b", bus.rd_b, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd1);
    check("reset_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    rst = 1'b0;
    count_busy(n, noisy);
    check("initial_clear_len", n, 32'd32);

    for (int i = 0; i < 32; i++) begin
      bus.we0 = 1'b1; bus.wa0 = 5'(i); bus.wd0 = 32'hDEAD;
      tick();
    end
    idle();
    bus.re_a = 1'b1; bus.ra_a = 5'd3;
    bus.re_b = 1'b1; bus.ra_b = 5'd0;
    tick();
    check("fill_read_3", bus.rd_a, 32'hDEAD);
    check("fill_read_0", bus.rd_b, 32'd0);

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n, noisy);
    check("reclear_len", n, 32'd32);
    bus.re_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.ra_a = 5'(i);
      tick();
      check($sformatf("cleared_%0d", i), bus.rd_a, 32'd0);
    end

    idle();
    for (int i = 1; i < 32; i++) begin
      bus.we0 = 1'b1; bus.wa0 = 5'(i); bus.wd0 = 32'(i * 10);
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      bus.re_a = 1'b1; bus.ra_a = 5'(i);
      bus.re_b = 1'b1; bus.ra_b = 5'(i - 1);
      tick();
      check($sformatf("basic_a_%0d", i), bus.rd_a, 32'(i * 10));
      check($sformatf("basic_b_%0d", i), bus.rd_b, 32'((i - 1) * 10));
    end

    for (int v = 0; v < 14; v++) begin
      bus.we0 = vecs[v].we0; bus.wa0 = vecs[v].wa0; bus.wd0 = vecs[v].wd0;
      bus.we1 = vecs[v].we1; bus.wa1 = vecs[v].wa1; bus.wd1 = vecs[v].wd1;
      bus.re_a = vecs[v].re_a; bus.ra_a = vecs[v].ra_a;
      bus.re_b = vecs[v].re_b; bus.ra_b = vecs[v].ra_b;
      tick();
      check($sformatf("vec%0d_rd_a", v), bus.rd_a, vecs[v].exp_a);
      check($sformatf("vec%0d_rd_b", v), bus.rd_b, vecs[v].exp_b);
      check($sformatf("vec%0d_conflict", v), {31'd0, bus.wr_conflict}, {31'd0, vecs[v].exp_conf});
      check($sformatf("vec%0d_nobypass_rd_a", v), bus_nb.rd_a, vecs[v].exp_nb_a);
    end

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("midclear_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h1234;
    bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h5678;
    bus.re_a = 1'b1; bus.ra_a = 5'd3;
    count_busy(n, noisy);
    check("midclear_len", n, 32'd32);
    check("midclear_quiet", noisy, 32'd0);
    idle();
    bus.re_a = 1'b1; bus.ra_a = 5'd3;
    tick();
    check("midclear_addr3", bus.rd_a, 32'd0);
    bus.ra_a = 5'd7;
    tick();
    check("midclear_addr7", bus.rd_a, 32'd0);
    bus.ra_a = 5'd9;
    tick();
    check("midclear_addr9", bus.rd_a, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
